// File: rtl/mem_port_arb_pkg.sv
// Shared constants and types for the SRAM port arbiter and its round-robin core.
package mem_port_arb_pkg;

    localparam int NREQ_DEFAULT = 3;
    localparam int AW_DEFAULT   = 16;
    localparam int DW_DEFAULT   = 8;

    // Requester slots: host loader, activation fetch, weight fetch.
    localparam int REQ_HOST = 0;
    localparam int REQ_ACT  = 1;
    localparam int REQ_WGT  = 2;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Bits needed to index n requesters; never zero so a single requester still gets a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with per-requester burst lock; grant is combinational,
// pointer and lock state update on the rising edge.
module rr_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            lock,
    output logic [NREQ-1:0]            gnt,
    output logic [idx_width(NREQ)-1:0] gnt_idx,
    output logic                       accept
);

    localparam int PW = idx_width(NREQ);

    logic [PW-1:0] ptr;
    arb_state_e    state;
    logic          release_lock;
    logic [PW-1:0] start;
    logic [PW-1:0] cand;
    logic [PW-1:0] win;
    logic          found;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // While locked the pointer sits on the owner; once the owner drops req or
    // lock, the search starts just past it so the others get the next slot.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        release_lock = (state == ARB_LOCKED) && !(req[ptr] && lock[ptr]);
        start        = release_lock ? next_idx(ptr) : ptr;
        found        = 1'b0;
        win          = '0;
        cand         = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(start) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        accept = found && enable && rstn;
        gnt    = '0;
        if (accept) begin
            gnt[win] = 1'b1;
        end
    end

    assign gnt_idx = win;

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr   <= '0;
            state <= ARB_OPEN;
        end else if (accept) begin
            ptr   <= lock[win] ? win : next_idx(win);
            state <= lock[win] ? ARB_LOCKED : ARB_OPEN;
        end else if (release_lock) begin
            state <= ARB_OPEN;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one single-port SRAM between NREQ requesters: round-robin grant,
// registered SRAM drive, fixed two-cycle read return tagged with the requester id.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [NREQ-1:0]    lock,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_cen,
    output logic               mem_wen,
    output logic [AW-1:0]      mem_a,
    output logic [DW-1:0]      mem_d,
    input  logic [DW-1:0]      mem_q,
    output logic               busy
);

    localparam int PW = idx_width(NREQ);

    typedef struct packed {
        logic          valid;
        logic          rd;
        logic [PW-1:0] id;
    } stage_t;

    logic [PW-1:0] gnt_idx;
    logic          accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    stage_t        s1;
    stage_t        s2;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .accept  (accept)
    );

    // Grant is one-hot, so an OR-style mux picks the winner's command.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // s1 is the SRAM access cycle, s2 the cycle mem_q is valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1      <= '0;
            s2      <= '0;
            mem_cen <= 1'b1;
            mem_wen <= 1'b1;
            mem_a   <= '0;
            mem_d   <= '0;
        end else begin
            s1.valid <= accept;
            s1.rd    <= accept && !sel_we;
            s1.id    <= gnt_idx;
            s2       <= s1;
            mem_cen  <= !accept;
            mem_wen  <= !(accept && sel_we);
            if (accept) begin
                mem_a <= sel_addr;
                mem_d <= sel_wdata;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (rstn && s2.valid && s2.rd) begin
            rvalid[s2.id] = 1'b1;
            rdata         = mem_q;
        end
    end

    assign busy = s1.valid | s2.valid;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rstn) (gnt & ~req) == '0);

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed vector table plus hand-written lock/enable/reset sequences and a
// randomized run against a reference memory for mem_port_arb.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic               enable;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_cen;
    logic               mem_wen;
    logic [AW-1:0]      mem_a;
    logic [DW-1:0]      mem_d;
    logic [DW-1:0]      mem_q;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic        en;
        logic [2:0]  req;
        logic [2:0]  we;
        logic [2:0]  lock;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [7:0]  wd0;
        logic [2:0]  e_gnt;
        logic        e_cen;
        logic        e_wen;
        logic [15:0] e_a;
        logic [7:0]  e_d;
        logic [2:0]  e_rv;
        logic [7:0]  e_rd;
        logic        e_busy;
    } vec_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_exp_t;

    vec_t    vecs [12];
    rd_exp_t rq [$];
    rd_exp_t e;

    logic [NREQ-1:0] pend;
    logic            p_we   [NREQ];
    logic [AW-1:0]   p_addr [NREQ];
    logic [DW-1:0]   p_wd   [NREQ];
    int              wait_cnt [NREQ];
    logic [NREQ-1:0] exp_rv;
    logic [DW-1:0]   exp_rd;

    always #5 clk = ~clk;

    mem_port_arb #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .lock    (lock),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .mem_cen (mem_cen),
        .mem_wen (mem_wen),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_q   (mem_q),
        .busy    (busy)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 8'hA5;
    endfunction

    // Synchronous single-port SRAM: read data appears the cycle after the access.
    initial begin
        mem_q = '0;
        for (int a = 0; a < (1 << AW); a++) sram[a] = pat(AW'(a));
        forever begin
            @(posedge clk);
            if (!mem_cen) begin
                if (!mem_wen) sram[mem_a] = mem_d;
                else          mem_q = sram[mem_a];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc_in(input logic en, input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
        enable = en;
        req    = r;
        we     = w;
        lock   = l;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     32'(gnt),     32'h0);
        check({tag, "_rvalid"},  32'(rvalid),  32'h0);
        check({tag, "_rdata"},   32'(rdata),   32'h0);
        check({tag, "_mem_cen"}, 32'(mem_cen), 32'h1);
        check({tag, "_mem_wen"}, 32'(mem_wen), 32'h1);
        check({tag, "_mem_a"},   32'(mem_a),   32'h0);
        check({tag, "_mem_d"},   32'(mem_d),   32'h0);
        check({tag, "_busy"},    32'(busy),    32'h0);
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = pat(AW'(a));

        //          en    req     we      lock    a0        a1        a2        wd0    gnt     cen   wen   a         d      rv      rd     busy
        vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b001, 1'b1, 1'b1, 16'h0000, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b010, 1'b0, 1'b1, 16'h0010, 8'h00, 3'b000, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b100, 1'b0, 1'b1, 16'h0020, 8'h00, 3'b001, 8'hB5, 1'b1};
        vecs[3]  = '{1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b001, 1'b0, 1'b1, 16'h0030, 8'h00, 3'b010, 8'h85, 1'b1};
        vecs[4]  = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b000, 1'b0, 1'b1, 16'h0010, 8'h00, 3'b100, 8'h95, 1'b1};
        vecs[5]  = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b000, 1'b1, 1'b1, 16'h0010, 8'h00, 3'b001, 8'hB5, 1'b1};
        vecs[6]  = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 8'h00, 3'b000, 1'b1, 1'b1, 16'h0010, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 3'b001, 3'b001, 3'b000, 16'h0100, 16'h0100, 16'h0030, 8'h55, 3'b001, 1'b1, 1'b1, 16'h0010, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 3'b010, 3'b000, 3'b000, 16'h0100, 16'h0100, 16'h0030, 8'h55, 3'b010, 1'b0, 1'b0, 16'h0100, 8'h55, 3'b000, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0100, 16'h0100, 16'h0030, 8'h55, 3'b000, 1'b0, 1'b1, 16'h0100, 8'h00, 3'b000, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0100, 16'h0100, 16'h0030, 8'h55, 3'b000, 1'b1, 1'b1, 16'h0100, 8'h00, 3'b010, 8'h55, 1'b1};
        vecs[11] = '{1'b1, 3'b000, 3'b000, 3'b000, 16'h0100, 16'h0100, 16'h0030, 8'h55, 3'b000, 1'b1, 1'b1, 16'h0100, 8'h00, 3'b000, 8'h00, 1'b0};

        rstn   = 1'b0;
        enable = 1'b0;
        req    = '0;
        we     = '0;
        lock   = '0;
        addr   = '0;
        wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        adv();
        rstn = 1'b1;

        // Round-robin order, read return, write-then-read.
        for (int v = 0; v < 12; v++) begin
            addr  = {vecs[v].a2, vecs[v].a1, vecs[v].a0};
            wdata = {8'h00, 8'h00, vecs[v].wd0};
            cyc_in(vecs[v].en, vecs[v].req, vecs[v].we, vecs[v].lock);
            check($sformatf("vec%0d_gnt", v),     32'(gnt),     32'(vecs[v].e_gnt));
            check($sformatf("vec%0d_mem_cen", v), 32'(mem_cen), 32'(vecs[v].e_cen));
            check($sformatf("vec%0d_mem_wen", v), 32'(mem_wen), 32'(vecs[v].e_wen));
            check($sformatf("vec%0d_mem_a", v),   32'(mem_a),   32'(vecs[v].e_a));
            check($sformatf("vec%0d_mem_d", v),   32'(mem_d),   32'(vecs[v].e_d));
            check($sformatf("vec%0d_rvalid", v),  32'(rvalid),  32'(vecs[v].e_rv));
            if (vecs[v].e_rv != 3'b000)
                check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].e_rd));
            check($sformatf("vec%0d_busy", v),    32'(busy),    32'(vecs[v].e_busy));
            adv();
        end

        // Burst lock: move the pointer to 1, hold requester 1 for four cycles, then release.
        addr  = {16'h0030, 16'h0020, 16'h0010};
        wdata = '0;
        cyc_in(1'b1, 3'b001, 3'b000, 3'b000);
        check("lock_pre_gnt", 32'(gnt), 32'h1);
        adv();
        for (int k = 0; k < 4; k++) begin
            cyc_in(1'b1, 3'b011, 3'b000, 3'b010);
            check($sformatf("lock_hold%0d_gnt", k), 32'(gnt), 32'(1 << REQ_ACT));
            adv();
        end
        cyc_in(1'b1, 3'b011, 3'b000, 3'b000);
        check("lock_release_gnt", 32'(gnt), 32'(1 << REQ_HOST));
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        check("lock_drain_busy", 32'(busy), 32'h0);
        adv();

        // Enable drops right after a read accept; the read still returns.
        cyc_in(1'b1, 3'b010, 3'b000, 3'b000);
        check("en_accept_gnt", 32'(gnt), 32'h2);
        adv();
        cyc_in(1'b0, 3'b111, 3'b000, 3'b000);
        check("en_low1_gnt", 32'(gnt), 32'h0);
        check("en_low1_mem_cen", 32'(mem_cen), 32'h0);
        check("en_low1_busy", 32'(busy), 32'h1);
        adv();
        cyc_in(1'b0, 3'b111, 3'b000, 3'b000);
        check("en_low2_gnt", 32'(gnt), 32'h0);
        check("en_low2_rvalid", 32'(rvalid), 32'h2);
        check("en_low2_rdata", 32'(rdata), 32'h85);
        check("en_low2_mem_cen", 32'(mem_cen), 32'h1);
        adv();
        cyc_in(1'b0, 3'b111, 3'b000, 3'b000);
        check("en_low3_gnt", 32'(gnt), 32'h0);
        check("en_low3_rvalid", 32'(rvalid), 32'h0);
        check("en_low3_mem_cen", 32'(mem_cen), 32'h1);
        check("en_low3_busy", 32'(busy), 32'h0);
        adv();

        // Reset one cycle after a read accept discards it; first grant afterwards is index 0.
        cyc_in(1'b1, 3'b100, 3'b000, 3'b000);
        check("rst_accept_gnt", 32'(gnt), 32'(1 << REQ_WGT));
        adv();
        rstn = 1'b0;
        cyc_in(1'b1, 3'b111, 3'b000, 3'b000);
        check("rst_gnt_forced", 32'(gnt), 32'h0);
        adv();
        cyc_in(1'b1, 3'b111, 3'b000, 3'b000);
        check_reset_outputs("rst_mid");
        adv();
        rstn = 1'b1;
        cyc_in(1'b1, 3'b111, 3'b000, 3'b000);
        check("rst_first_gnt", 32'(gnt), 32'h1);
        check("rst_r3_rvalid", 32'(rvalid), 32'h0);
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        check("rst_r4_rvalid", 32'(rvalid), 32'h0);
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        check("rst_r5_rvalid", 32'(rvalid), 32'h1);
        check("rst_r5_rdata", 32'(rdata), 32'hB5);
        adv();
        cyc_in(1'b1, 3'b000, 3'b000, 3'b000);
        check("rst_r6_busy", 32'(busy), 32'h0);
        adv();

        // Random traffic: requests held until granted, reads checked against a reference memory.
        pend   = '0;
        enable = 1'b1;
        lock   = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_we[i]     = 1'b0;
            p_addr[i]   = '0;
            p_wd[i]     = '0;
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && cyc < 9990 && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    p_we[i]     = 1'($urandom_range(0, 1));
                    p_addr[i]   = AW'(32'h0200 + $urandom_range(0, 15));
                    p_wd[i]     = DW'($urandom_range(0, 255));
                    wait_cnt[i] = 0;
                end
                we[i]             = p_we[i];
                addr[i*AW +: AW]  = p_addr[i];
                wdata[i*DW +: DW] = p_wd[i];
            end
            req = pend;
            @(negedge clk);
            exp_rv = '0;
            exp_rd = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e      = rq.pop_front();
                exp_rv = NREQ'(1 << e.id);
                exp_rd = e.data;
            end
            check("rand_rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv != '0) check("rand_rdata", 32'(rdata), 32'(exp_rd));
            check("rand_gnt_onehot", 32'($onehot0(gnt)), 32'h1);
            check("rand_gnt_in_req", 32'(gnt & ~req), 32'h0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt[i]) begin
                    check($sformatf("rand_wait%0d", i), 32'(wait_cnt[i] < NREQ), 32'h1);
                    if (p_we[i]) ref_mem[p_addr[i]] = p_wd[i];
                    else         rq.push_back('{cyc + 2, i, ref_mem[p_addr[i]]});
                    pend[i] = 1'b0;
                end else if (req[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] == NREQ)
                        check($sformatf("rand_starve%0d", i), 32'(wait_cnt[i]), 32'(NREQ - 1));
                end
            end
            adv();
        end
        check("rand_drain", 32'(rq.size()), 32'h0);
        check("rand_pending", 32'(pend), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of requesters (index 0 host loader, 1 activation fetch, 2 weight fetch).
REQ-002 Parameter AW, default 16, SHALL set the SRAM address width.
REQ-003 Parameter DW, default 8, SHALL set the SRAM data width.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  high permits new grants.
REQ-007 req  in  NREQ  per-requester access request.
REQ-008 we  in  NREQ  per-requester write (1) / read (0).
REQ-009 addr  in  NREQ*AW  per-requester address; slice i is addr[i*AW +: AW].
REQ-010 wdata  in  NREQ*DW  per-requester write data, sliced the same way.
REQ-011 lock  in  NREQ  per-requester burst lock.
REQ-012 gnt  out  NREQ  one-hot grant, combinational from req, enable and the arbiter state.
REQ-013 rvalid  out  NREQ  one-hot read-data valid.
REQ-014 rdata  out  DW  read data, shared by all requesters.
REQ-015 mem_cen, mem_wen  out  1 each  active-low SRAM chip enable and write enable, registered.
REQ-016 mem_a  out  AW, mem_d  out  DW  SRAM address and write data, registered.
REQ-017 mem_q  in  DW  SRAM read data, valid one cycle after the access cycle.
REQ-018 busy  out  1  high while any access is in flight.

Function
REQ-019 At most one gnt bit SHALL be high per cycle; an access is accepted in cycle T when req[i] and gnt[i] are both high.
REQ-020 The winner SHALL be the first requesting index at or after the round-robin pointer, wrapping modulo NREQ.
REQ-021 After an unlocked accept of index i, the pointer SHALL become (i+1) mod NREQ; if no access is accepted, the pointer SHALL hold.
REQ-022 If lock[i] is high in the accept cycle, the pointer SHALL stay at i. The lock SHALL release on the first cycle req[i] or lock[i] is low.
REQ-023 For an access accepted in cycle T, cycle T+1 SHALL drive mem_cen=0, mem_wen=~we[i], mem_a=addr slice, mem_d=wdata slice.
REQ-024 A read accepted in cycle T SHALL assert rvalid[i] in cycle T+2 with rdata=mem_q; the latency is fixed at 2.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Back-to-back accepts SHALL sustain one access per cycle, with the pipeline carrying the requester id and read flag per stage.
REQ-027 In a cycle with no accept, the following cycle SHALL drive mem_cen=1 and mem_wen=1, and mem_a/mem_d SHALL hold their previous values.
REQ-028 enable low SHALL force gnt=0; accesses already accepted SHALL still complete, including rvalid.
REQ-029 Without lock, a continuously requesting index SHALL be granted within NREQ cycles.
REQ-030 busy SHALL equal the OR of both pipeline-stage valid flags.

Reset
REQ-031 While rstn=0: gnt=0, rvalid=0, rdata=0, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0, busy=0, pointer=0, lock state cleared.
REQ-032 Reset mid-operation SHALL discard in-flight accesses; no rvalid SHALL appear for them after rstn rises.

Structure
REQ-033 A shared package SHALL hold the AW/DW defaults, NREQ default, and requester index constants REQ_HOST=0, REQ_ACT=1, REQ_WGT=2.
REQ-034 The round-robin pointer and one-hot grant logic SHALL be a sub-module named rr_arbiter, parameterized by NREQ with lock support.

Verification
REQ-035 req=3'b111, all reads, addr 0x0010/0x0020/0x0030, lock=0 -> grants in order 0,1,2,0 on consecutive cycles; mem_a 0x0010,0x0020,0x0030; rvalid one-hot 001,010,100 at T+2.
REQ-036 req[0] write 0x55 to 0x0100, then req[1] read 0x0100 -> mem_wen=0 then 1; rvalid[1] with rdata=0x55 two cycles after the read grant; no rvalid[0].
REQ-037 req=3'b011, lock[1]=1 for 4 cycles -> gnt[1] held 4 cycles; gnt[0] in the cycle after lock[1] falls.
REQ-038 enable falls the cycle after a read accept -> gnt=0 while enable is low; the pending rvalid still fires; mem_cen=1 afterwards.
REQ-039 rstn=0 asserted one cycle after a read accept -> no rvalid after reset; all outputs hold reset values; the first grant after reset goes to index 0.
REQ-040 Random req/we over 10k cycles vs. a reference memory model -> every read returns the last written data; no requester waits longer than NREQ cycles unlocked.
